mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 15, bus wait cycles (REQ+WAIT) before timeout error.
REQ-002 SHALL have port: clk  in  1  clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-high (asserted = 1).
REQ-004 SHALL have ports from ex: ls_load_i in 1; ls_store_i in 1; ls_funct3_i in 3 (RV32I width/sign code); ls_addr_i in 32; ls_wdata_i in 32.
REQ-005 SHALL have pass-through ports from ex: rd_we_i in 1; rd_addr_i in 5; rd_data_i in 32 (ALU result).
REQ-006 SHALL have data bus ports: dbus_req_o out 1; dbus_we_o out 1; dbus_addr_o out 32 (word-aligned); dbus_be_o out 4; dbus_wdata_o out 32; dbus_gnt_i in 1; dbus_rvalid_i in 1; dbus_rdata_i in 32.
REQ-007 SHALL have ports to mem_wb: rd_we_o out 1; rd_data_o out 32; rd_addr_o out 5.
REQ-008 SHALL have ports: stall_o out 1 (freeze upstream); err_o out 1 (one-cycle error pulse).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-010 Non-memory op (ls_load_i=ls_store_i=0) SHALL pass rd_we_i/rd_addr_i/rd_data_i combinationally to outputs, stall_o=0.
REQ-011 Memory op in IDLE SHALL assert dbus_req_o same cycle; dbus_gnt_i=1 -> WAIT, else -> REQ.
REQ-012 In REQ, dbus_req_o SHALL stay 1 with stable addr/be/we/wdata until dbus_gnt_i=1, then -> WAIT.
REQ-013 In WAIT, dbus_rvalid_i=1 SHALL -> IDLE; for loads rd_we_o=1, rd_data_o=formatted dbus_rdata_i, same cycle.
REQ-014 Stores SHALL also wait for dbus_rvalid_i (write ack); rd_we_o=0 on completion.
REQ-015 stall_o SHALL be 1 for every memory-op cycle except the completing (rvalid) cycle; upstream inputs held stable while stall_o=1.
REQ-016 rd_we_o SHALL be 0 in all memory-op cycles other than load completion.
REQ-017 Load formatting: lane=ls_addr_i[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-018 Stores: SB replicates byte to all 4 lanes, be=0001<<addr[1:0]; SH replicates halfword, be=0011<<{addr[1],0}; SW be=1111.
REQ-019 Loads SHALL drive dbus_we_o=0, be as per width; dbus_addr_o={ls_addr_i[31:2],2'b00}.
REQ-020 Wait counter SHALL clear on entering REQ from IDLE and increment each REQ/WAIT cycle; reaching MAX_WAIT SHALL pulse err_o, drop dbus_req_o, rd_we_o=0, -> IDLE, stall_o=0 that cycle.
REQ-021 dbus_rvalid_i in IDLE or REQ SHALL be ignored.
REQ-022 Unknown funct3 on a memory op SHALL pulse err_o, no bus request, no stall.

Reset
REQ-023 rst_n=1 SHALL force IDLE, counter 0, dbus_req_o=0, stall_o=0, err_o=0, rd_we_o=0 next edge, abandoning any transaction.
REQ-024 Reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-025 Macro MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL issue no request, pulse err_o, rd_we_o=0, stall_o=0.
REQ-026 Macro undefined: offending low address bits SHALL be ignored (half uses addr[1], word uses aligned word), no error.

Structure
REQ-027 funct3 codes, FSM encoding, REG_BUS/REG_ADDR_BUS widths SHALL live in shared defines.v.
REQ-028 Load extension and store lane/be generation SHALL be one combinational sub-module lsu_align.

Verification
REQ-029 ALU op rd_we_i=1, rd_addr_i=5, rd_data_i=0x1234 -> same-cycle outputs, stall_o=0, dbus_req_o=0.
REQ-030 LB addr 0x1003, gnt cycle 0, rvalid cycle 2, rdata 0x80FF_FFFF -> rd_data_o=0xFFFF_FF80, rd_we_o=1 cycle 2 only, stall_o=1 cycles 0-1.
REQ-031 SH addr 0x2002 wdata 0xABCD, gnt delayed 3 cycles -> req held 4 cycles, be=1100, wdata=0xABCD_ABCD, rd_we_o=0 at ack.
REQ-032 LW, gnt given, no rvalid, MAX_WAIT=15 -> err_o pulse at cycle 15, IDLE, stall_o=0.
REQ-033 LW addr 0x3001 with MISALIGN_CHECK_EN -> err_o=1, dbus_req_o=0; without -> request to 0x3000, be=1111.
REQ-034 rst_n=1 during WAIT then late rvalid -> dbus_req_o=0, rd_we_o=0, rvalid ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and opcode legality helpers.
package mem_lsu_pkg;

   localparam int unsigned REG_BUS      = 32;
   localparam int unsigned REG_ADDR_BUS = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_e;

   function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
      if (is_store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b01:   return lane[0];
         2'b10:   return |lane;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational byte-lane steering for stores (be, replicated
// wdata) and sign/zero extension of load data.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [2:0]         funct3_i,
   input  logic [1:0]         lane_i,
   input  logic [REG_BUS-1:0] wdata_i,
   input  logic [REG_BUS-1:0] rdata_i,
   output logic [3:0]         be_o,
   output logic [REG_BUS-1:0] wdata_o,
   output logic [REG_BUS-1:0] rdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[{lane_i, 3'b000} +: 8];
      half_v = rdata_i[{lane_i[1], 4'b0000} +: 16];

      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << lane_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << {lane_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            be_o    = '1;
            wdata_o = wdata_i;
         end
      endcase

      case (funct3_i)
         F3_B:    rdata_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   rdata_o = {24'd0, byte_v};
         F3_H:    rdata_o = {{16{half_v[15]}}, half_v};
         F3_HU:   rdata_o = {16'd0, half_v};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit with IDLE/REQ/WAIT bus handshake and wait timeout.
// Define MISALIGN_CHECK_EN to reject misaligned half/word accesses with err_o.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ls_load_i,
   input  logic                    ls_store_i,
   input  logic [2:0]              ls_funct3_i,
   input  logic [REG_BUS-1:0]      ls_addr_i,
   input  logic [REG_BUS-1:0]      ls_wdata_i,
   input  logic                    rd_we_i,
   input  logic [REG_ADDR_BUS-1:0] rd_addr_i,
   input  logic [REG_BUS-1:0]      rd_data_i,
   output logic                    dbus_req_o,
   output logic                    dbus_we_o,
   output logic [REG_BUS-1:0]      dbus_addr_o,
   output logic [3:0]              dbus_be_o,
   output logic [REG_BUS-1:0]      dbus_wdata_o,
   input  logic                    dbus_gnt_i,
   input  logic                    dbus_rvalid_i,
   input  logic [REG_BUS-1:0]      dbus_rdata_i,
   output logic                    rd_we_o,
   output logic [REG_BUS-1:0]      rd_data_o,
   output logic [REG_ADDR_BUS-1:0] rd_addr_o,
   output logic                    stall_o,
   output logic                    err_o
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   lsu_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mem_op, bad_op, timeout;
   logic [REG_BUS-1:0] ld_data;

   lsu_align u_align (
      .funct3_i (ls_funct3_i),
      .lane_i   (ls_addr_i[1:0]),
      .wdata_i  (ls_wdata_i),
      .rdata_i  (dbus_rdata_i),
      .be_o     (dbus_be_o),
      .wdata_o  (dbus_wdata_o),
      .rdata_o  (ld_data)
   );

   assign dbus_we_o   = ls_store_i;
   assign dbus_addr_o = {ls_addr_i[31:2], 2'b00};
   assign rd_addr_o   = rd_addr_i;

   always_comb begin
      mem_op  = ls_load_i | ls_store_i;
`ifdef MISALIGN_CHECK_EN
      bad_op  = ~f3_valid(ls_store_i, ls_funct3_i) | misaligned(ls_funct3_i, ls_addr_i[1:0]);
`else
      bad_op  = ~f3_valid(ls_store_i, ls_funct3_i);
`endif
      // cnt_q counts completed REQ/WAIT cycles, so the current cycle is number cnt_q+1
      timeout = (cnt_q == CW'(MAX_WAIT - 1));

      state_d    = state_q;
      cnt_d      = cnt_q;
      dbus_req_o = 1'b0;
      stall_o    = 1'b0;
      err_o      = 1'b0;
      rd_we_o    = rd_we_i & ~mem_op;
      rd_data_o  = rd_data_i;

      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               if (bad_op) begin
                  err_o = 1'b1;
               end else begin
                  dbus_req_o = 1'b1;
                  stall_o    = 1'b1;
                  cnt_d      = '0;
                  state_d    = dbus_gnt_i ? ST_WAIT : ST_REQ;
               end
            end
         end
         ST_REQ: begin
            rd_we_o = 1'b0;
            cnt_d   = cnt_q + CW'(1);
            if (timeout) begin
               err_o   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               dbus_req_o = 1'b1;
               stall_o    = 1'b1;
               if (dbus_gnt_i) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            rd_we_o = 1'b0;
            cnt_d   = cnt_q + CW'(1);
            if (dbus_rvalid_i) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (ls_load_i && !ls_store_i) begin
                  rd_we_o   = 1'b1;
                  rd_data_o = ld_data;
               end
            end else if (timeout) begin
               err_o   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset wins over any same-cycle bus or completion activity
      if (rst_n) begin
         dbus_req_o = 1'b0;
         stall_o    = 1'b0;
         err_o      = 1'b0;
         rd_we_o    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
